// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the execute-stage units.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    MUL_LO = 2'b00,
    MUL_HI = 2'b01,
    DIV_Q  = 2'b10,
    DIV_R  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_div(input op_e op_i);
    return op_i[1];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit sharing one
// 2*DATA_W shift register, one adder/subtractor and one iteration counter.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              div_by_zero
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;     // multiplicand for MUL, divisor for DIV
  logic [2*DATA_W-1:0] acc_q, acc_d;       // {hi, lo} product or {remainder, quotient}
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic                dbz_q, dbz_d;

  logic                div_op;
  logic [DATA_W:0]     partial;
  logic [DATA_W+1:0]   sum;
  logic                neg;
  logic [2*DATA_W-1:0] acc_step;

  // Shared adder: MUL adds the multiplicand to the upper half, DIV trial-subtracts
  // the divisor from the shifted 9-bit partial remainder.
  always_comb begin
    div_op  = is_div(op_q);
    partial = div_op ? acc_q[2*DATA_W-1:DATA_W-1] : {1'b0, acc_q[2*DATA_W-1:DATA_W]};
    if (div_op) begin
      sum = {1'b0, partial} - {2'b00, opnd_q};
    end else begin
      sum = {1'b0, partial} + {2'b00, opnd_q};
    end
    neg = sum[DATA_W+1];
    if (div_op) begin
      acc_step = {(neg ? partial[DATA_W-1:0] : sum[DATA_W-1:0]), acc_q[DATA_W-2:0], ~neg};
    end else if (acc_q[0]) begin
      acc_step = {sum[DATA_W:0], acc_q[DATA_W-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*DATA_W-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op_e'(op);
          opnd_d  = op[1] ? operand_b : operand_a;
          acc_d   = {{DATA_W{1'b0}}, (op[1] ? operand_a : operand_b)};
          cnt_d   = '0;
          dest_d  = dest_addr;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d   = DONE;
          // Low half holds MUL_LO / quotient, high half MUL_HI / remainder.
          result_d  = op_q[0] ? acc_step[2*DATA_W-1:DATA_W] : acc_step[DATA_W-1:0];
          wb_addr_d = dest_q;
          dbz_d     = div_op && (opnd_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= MUL_LO;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign wb_en       = done;
  assign result      = result_q;
  assign wb_addr     = wb_addr_q;
  assign div_by_zero = dbz_q & done;

endmodule
